// File: rtl/avr_serial_tx.sv
// UART transmitter toward the AVR: bytes from fabric logic are buffered in a
// small FIFO and sent as 8N1 frames, LSB first, on the avr_rx pin. The AVR's
// avr_rx_busy line (block) holds back new frames while its buffer is full.
module avr_serial_tx #(
    parameter int CLK_PER_BIT = 100,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        tx,
    input  logic                        block,
    input  logic [7:0]                  data,
    input  logic                        new_data,
    output logic                        ready,
    output logic                        overflow,
    output logic                        idle,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] clk_cnt, clk_cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic          tx_next;
    logic          block_meta, block_s;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ready      = !full;
    assign push       = new_data && !full;
    assign fifo_count = wr_ptr - rd_ptr;
    assign idle       = (state == IDLE) && empty;

    // Two-flop synchronizer for block; resets to 1 so the link starts out blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            block_meta <= 1'b1;
            block_s    <= 1'b1;
        end else begin
            block_meta <= block;
            block_s    <= block_meta;
        end
    end

    // FIFO storage; no reset needed since the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= data;
        end
    end

    // FIFO pointers and the one-cycle overflow pulse for rejected writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            overflow <= new_data && full;
        end
    end

    // Frame sequencer state and the registered, glitch-free tx output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    // Next-state logic; block is only looked at in IDLE so a started frame always completes.
    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !block_s) begin
                    pop          = 1'b1;
                    shift_next   = mem[rd_ptr[AW-1:0]];
                    clk_cnt_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (clk_cnt == CNT_MAX) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (clk_cnt == CNT_MAX) begin
                    clk_cnt_next = '0;
                    shift_next   = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end
            end
            STOP: begin
                if (clk_cnt == CNT_MAX) begin
                    clk_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // tx follows the state being entered so it changes exactly on the clock edge.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_avr_serial_tx.sv
// Self-checking bench for avr_serial_tx: a cycle-level reference model built
// from frame timing arithmetic predicts the status outputs and tx, and a
// serial-decoding monitor pops expected bytes from a scoreboard queue.
module tb_avr_serial_tx;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx;
    logic       block = 1'b0;
    logic [7:0] data = 8'h00;
    logic       new_data = 1'b0;
    logic       ready;
    logic       overflow;
    logic       idle;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb[$];
    logic [7:0] m_fifo[$];
    int         cyc         = 0;
    int         frame_start = -100000;
    logic [7:0] frame_byte  = 8'h00;
    logic       blk_h1      = 1'b1;
    logic       blk_h2      = 1'b1;
    logic       exp_ovf     = 1'b0;
    logic       cur_block   = 1'b0;

    avr_serial_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .tx(tx),
        .block(block),
        .data(data),
        .new_data(new_data),
        .ready(ready),
        .overflow(overflow),
        .idle(idle),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
        end
    endtask

    function automatic logic expTx();
        int off;
        int b;
        off = cyc - frame_start;
        if (off >= 0 && off < FRAME) begin
            b = off / CPB;
            if (b == 0) return 1'b0;
            if (b <= 8) return frame_byte[b-1];
        end
        return 1'b1;
    endfunction

    function automatic logic inFrame();
        return (cyc - frame_start) >= 0 && (cyc - frame_start) < FRAME;
    endfunction

    // Reference model: what the edge just taken does, given the inputs driven before it.
    task automatic modelEdge(input logic nd, input logic [7:0] d, input logic blk, input logic r);
        logic acc;
        logic pop;
        if (r) begin
            m_fifo.delete();
            sb.delete();
            frame_start = -100000;
            blk_h1      = 1'b1;
            blk_h2      = 1'b1;
            exp_ovf     = 1'b0;
        end else begin
            pop     = (m_fifo.size() > 0) && (blk_h2 == 1'b0) && (cyc >= frame_start + FRAME + 1);
            acc     = nd && (m_fifo.size() < DEPTH);
            exp_ovf = nd && !acc;
            if (pop) begin
                frame_byte  = m_fifo.pop_front();
                frame_start = cyc;
            end
            if (acc) begin
                m_fifo.push_back(d);
                sb.push_back(d);
            end
            blk_h2 = blk_h1;
            blk_h1 = blk;
        end
    endtask

    task automatic applyStimulus(input logic nd, input logic [7:0] d, input logic blk, input logic r);
        @(negedge clk);
        new_data = nd;
        data     = d;
        block    = blk;
        rst      = r;
        @(posedge clk);
        cyc++;
        modelEdge(nd, d, blk, r);
        #1;
        checkOutput("tx", tx, expTx());
        checkOutput("ready", ready, (m_fifo.size() < DEPTH));
        checkOutput("overflow", overflow, exp_ovf);
        checkOutput("fifo_count", fifo_count, m_fifo.size());
        checkOutput("idle", idle, (m_fifo.size() == 0) && !inFrame());
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, cur_block, 1'b0);
    endtask

    task automatic writeByte(input logic [7:0] d);
        applyStimulus(1'b1, d, cur_block, 1'b0);
    endtask

    // Serial monitor: decodes frames mid-bit and compares against the scoreboard.
    initial begin
        int         t;
        logic       active;
        logic [7:0] rx;
        active = 1'b0;
        t      = 0;
        rx     = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (rst === 1'b1) begin
                active = 1'b0;
            end else begin
                if (!active && tx === 1'b0) begin
                    active = 1'b1;
                    t      = 0;
                end
                if (active) begin
                    if (t % CPB == CPB / 2) begin
                        if (t / CPB == 0) begin
                            checkOutput("start_bit", tx, 1'b0);
                        end else if (t / CPB <= 8) begin
                            rx[t / CPB - 1] = tx;
                        end else begin
                            checkOutput("stop_bit", tx, 1'b1);
                            if (sb.size() == 0) begin
                                checks++;
                                failures++;
                                $display("[TB] FAIL rx_byte at cycle %0d: got %0h expected no frame", cyc, rx);
                            end else begin
                                checkOutput("rx_byte", rx, sb.pop_front());
                            end
                            active = 1'b0;
                        end
                    end
                    t++;
                end
            end
        end
    end

    initial begin
        logic       nd;
        logic       r;
        logic [7:0] d;

        // Reset state
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        idleCycles(3);

        // Single byte frame
        writeByte(8'hA5);
        idleCycles(90);

        // Three back-to-back bytes
        writeByte(8'h00);
        writeByte(8'hFF);
        writeByte(8'h3C);
        idleCycles(260);

        // Flow control: fill while blocked, then release
        cur_block = 1'b1;
        idleCycles(3);
        for (int i = 0; i < 6; i++) writeByte(8'($urandom));
        idleCycles(10);
        cur_block = 1'b0;
        idleCycles(350);

        // Block raised mid-frame
        writeByte(8'h5A);
        writeByte(8'hC3);
        idleCycles(21);
        cur_block = 1'b1;
        idleCycles(120);
        cur_block = 1'b0;
        idleCycles(200);

        // Reset during DATA bit 3
        writeByte(8'h96);
        writeByte(8'h11);
        idleCycles(35);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        idleCycles(20);
        writeByte(8'h7E);
        idleCycles(100);

        // Full FIFO with pop and write on the same edge
        cur_block = 1'b1;
        idleCycles(3);
        for (int i = 0; i < 4; i++) writeByte(8'($urandom));
        idleCycles(3);
        cur_block = 1'b0;
        for (int i = 0; i < 6; i++) writeByte(8'($urandom));
        idleCycles(400);

        // Randomized traffic with block toggling and rare resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) cur_block = ~cur_block;
            nd = ($urandom_range(11) == 0);
            r  = ($urandom_range(1999) == 0);
            d  = 8'($urandom);
            applyStimulus(nd, d, cur_block, r);
        end

        // Drain everything still queued
        cur_block = 1'b0;
        idleCycles(600);
        checkOutput("frames_pending", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
